// File: rtl/keccak_rc_generator_pkg.sv
// Shared types, constants and constant functions for the Keccak iota round-constant generator.
// The rc LFSR is x^8+x^6+x^5+x^4+1, stepped by multiplying by x modulo that polynomial.
package keccak_rc_generator_pkg;

  localparam logic [7:0] RC_POLY = 8'h71;
  localparam logic [7:0] RC_SEED = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rc_state_e;

  function automatic bit lane_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic int lane_log2(input int w);
    case (w)
      8:       return 3;
      16:      return 4;
      32:      return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int nr_full(input int l);
    return 12 + 2 * l;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? RC_POLY : 8'h00);
  endfunction

  // Only ever evaluated at elaboration to seed the LFSR for a reduced-round start.
  function automatic logic [7:0] lfsr_state_at(input int t);
    logic [7:0] s;
    s = RC_SEED;
    for (int i = 0; i < t; i++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/keccak_rc_generator_if.sv
// Control/constant bundle between the round controller (master) and the rc generator (slave).
interface keccak_rc_generator_if #(
  parameter int LANE_W = 64,
  parameter int N_PAR  = 1
);

  logic                      start_i;
  logic                      advance_i;
  logic                      busy_o;
  logic [4:0]                round_idx_o;
  logic [N_PAR*LANE_W-1:0]   round_constant_o;
  logic                      last_o;
  logic                      done_o;

  modport master (
    output start_i,
    output advance_i,
    input  busy_o,
    input  round_idx_o,
    input  round_constant_o,
    input  last_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  advance_i,
    output busy_o,
    output round_idx_o,
    output round_constant_o,
    output last_o,
    output done_o
  );

endinterface

// File: rtl/keccak_rc_generator_lfsr.sv
// Combinational STEPS-deep unroll of the rc LFSR: emits the rc bit seen before each step
// and the state reached after all STEPS steps.
module keccak_rc_lfsr_unroll
  import keccak_rc_generator_pkg::*;
#(
  parameter int STEPS = 7
) (
  input  logic [7:0]       state_i,
  output logic [7:0]       state_o,
  output logic [STEPS-1:0] rc_o
);

  logic [7:0] walk;

  always_comb begin
    walk = state_i;
    rc_o = '0;
    for (int s = 0; s < STEPS; s++) begin
      rc_o[s] = walk[0];
      walk    = lfsr_step(walk);
    end
    state_o = walk;
  end

endmodule

// File: rtl/keccak_rc_generator.sv
// On-the-fly Keccak-p iota round-constant source: N_PAR consecutive RC values per step,
// truncated to LANE_W, driven by an IDLE/RUN controller with start/advance handshakes.
module keccak_rc_generator
  import keccak_rc_generator_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int N_RUN  = nr_full(lane_log2(LANE_W)),
  parameter int N_PAR  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  keccak_rc_generator_if.slave bus
);

  localparam int         L           = lane_log2(LANE_W);
  localparam int         NR_FULL     = nr_full(L);
  localparam int         FIRST_IR    = NR_FULL - N_RUN;
  localparam int         STEPS       = 7 * N_PAR;
  localparam logic [7:0] START_STATE = lfsr_state_at(7 * FIRST_IR);
  localparam logic [4:0] FIRST_IR_V  = 5'(FIRST_IR);
  localparam logic [4:0] N_PAR_V     = 5'(N_PAR);
  localparam logic [5:0] NR_FULL_V   = 6'(NR_FULL);

  if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
    $error("keccak_rc_generator: LANE_W must be 8, 16, 32 or 64");
  end
  if ((N_RUN < 1) || (N_RUN > NR_FULL)) begin : g_bad_n_run
    $error("keccak_rc_generator: N_RUN must lie in 1..NR_FULL");
  end
  if ((N_PAR < 1) || ((N_RUN % N_PAR) != 0)) begin : g_bad_n_par
    $error("keccak_rc_generator: N_RUN must be a multiple of N_PAR");
  end

  rc_state_e  state_q, state_d;
  logic [4:0] ir_q, ir_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       done_q, done_d;

  logic [7:0]              lfsr_next;
  logic [STEPS-1:0]        rc_bits;
  logic                    last;
  logic [N_PAR*LANE_W-1:0] rc_word;
  logic                    rc_bits_unused;

  keccak_rc_lfsr_unroll #(
    .STEPS (STEPS)
  ) u_unroll (
    .state_i (lfsr_q),
    .state_o (lfsr_next),
    .rc_o    (rc_bits)
  );

  // Narrow lanes never look at rc(6+7*ir); fold the spare bits away.
  assign rc_bits_unused = ^rc_bits;

  assign last = (state_q == ST_RUN) && (({1'b0, ir_q} + {1'b0, N_PAR_V}) == NR_FULL_V);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ir_q    <= 5'd0;
      lfsr_q  <= RC_SEED;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      lfsr_q  <= lfsr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    lfsr_d  = lfsr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
          ir_d    = FIRST_IR_V;
          lfsr_d  = START_STATE;
        end
      end
      ST_RUN: begin
        if (bus.advance_i) begin
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ir_d   = ir_q + N_PAR_V;
            lfsr_d = lfsr_next;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit 2^j-1 of slice k carries rc(j + 7*(ir+k)), which is rc_bits[7*k + j].
  always_comb begin
    rc_word = '0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < N_PAR; k++) begin
        for (int j = 0; j <= L; j++) begin
          rc_word[k*LANE_W + (1 << j) - 1] = rc_bits[7*k + j];
        end
      end
    end
  end

  assign bus.busy_o           = (state_q == ST_RUN);
  assign bus.round_idx_o      = ir_q;
  assign bus.round_constant_o = rc_word;
  assign bus.last_o           = last;
  assign bus.done_o           = done_q;

endmodule
